// File: rtl/seq_muldiv32_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation
// encodings, FSM state type and iteration sizing.
// Ports: none (package only).
package seq_muldiv32_pkg;

  // Operand width and number of shift/add-sub iterations per operation.
  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  // Iteration counter width; holds 0..MD_ITER-1.
  localparam int CNT_W = $clog2(MD_ITER);

  // Operation select encodings, sampled from op together with start.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_muldiv32_if.sv
// Request/result bundle between the execute stage and seq_muldiv32.
// Ports: start/op/a/b from the requester; busy/done/hi/lo/dz back to it.
// The master modport is the requester side, slave is the unit itself.
interface seq_muldiv32_if;

  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, dz
  );

endinterface

// File: rtl/seq_muldiv32_addsub33.sv
// Shared 33-bit adder/subtractor used once per iteration by seq_muldiv32.
// Ports: x, y (33-bit operands), sub (1 = x - y, 0 = x + y), r (34-bit result).
// Purely combinational; r[33] is the carry on add and the borrow on subtract.
module addsub33 (
  input  logic [32:0] x,
  input  logic [32:0] y,
  input  logic        sub,
  output logic [33:0] r
);

  // Zero-extending both sides to 34 bits makes r[33] set exactly when the
  // add carries out or the subtract underflows (x < y).
  always_comb begin
    if (sub) begin
      r = {1'b0, x} - {1'b0, y};
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
  end

endmodule

// File: rtl/seq_muldiv32.sv
// Multi-cycle unsigned 32x32 multiply (shift-add) and 32/32 divide (restoring)
// sharing one 33-bit add/sub over 32 iterations. Latency: 33 cycles from the
// accept edge to done, 1 cycle for divide-by-zero. Flow control: start is only
// taken in IDLE or DONE; start while busy is dropped, not queued.
// Ports: clk, rst (async active-high), bus (slave side: start/op/a/b in,
// busy/done/hi/lo/dz out).
module seq_muldiv32
  import seq_muldiv32_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic          clk,
  input  logic          rst,
  seq_muldiv32_if.slave bus
);

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             op_q;
  // Holds the multiplicand for MUL and the divisor for DIV; hi/lo carry the
  // other operand and the evolving partial result.
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dz_q;

  logic accept;
  logic div_zero;
  logic last_iter;

  logic [32:0] as_x;
  logic [32:0] as_y;
  logic        as_sub;
  logic [33:0] as_r;

  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  assign accept    = bus.start && (state != S_RUN);
  assign div_zero  = (bus.op == OP_DIV) && (bus.b == '0);
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A start in the done cycle chains straight into the next operation.
        if (accept) begin
          state_nxt = div_zero ? S_DONE : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared add/sub: MUL always adds, DIV always subtracts.
  // ---------------------------------------------------------------------------
  always_comb begin
    as_sub = (op_q == OP_DIV);
    if (op_q == OP_DIV) begin
      // Trial subtract of the divisor from the partial remainder with the
      // next dividend bit shifted in.
      as_x = {hi_q, lo_q[WIDTH-1]};
      as_y = {1'b0, opnd_q};
    end else begin
      // Add the multiplicand when the current multiplier bit is set.
      as_x = {1'b0, hi_q};
      as_y = lo_q[0] ? {1'b0, opnd_q} : '0;
    end
  end

  addsub33 u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (as_sub),
    .r   (as_r)
  );

  // Next hi/lo for one iteration.
  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (op_q == OP_DIV) begin
      if (!as_r[33]) begin
        // No borrow: keep the difference, quotient bit is 1. The remainder is
        // below the divisor, so bit 32 of the difference is always zero.
        hi_nxt = as_r[31:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        // Borrow: restore by just shifting, quotient bit is 0.
        hi_nxt = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // {hi,lo} <= {sum[32:0], lo[31:1]}: the consumed multiplier bit drops
      // out of lo while the sum's LSB becomes a finished product bit.
      hi_nxt = as_r[32:1];
      lo_nxt = {as_r[0], lo_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Operand, result and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= OP_MUL;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= bus.op;
      dz_q <= div_zero;
      if (div_zero) begin
        // Divide-by-zero bypasses the iterations entirely.
        opnd_q <= bus.b;
        hi_q   <= bus.a;
        lo_q   <= '1;
      end else if (bus.op == OP_DIV) begin
        opnd_q <= bus.b;
        hi_q   <= '0;
        lo_q   <= bus.a;
      end else begin
        opnd_q <= bus.a;
        hi_q   <= '0;
        lo_q   <= bus.b;
      end
    end else if (state == S_RUN) begin
      cnt  <= cnt + 1'b1;
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_seq_muldiv32.sv
// Self-checking bench for seq_muldiv32: directed cases plus random operands
// checked against plain 64-bit multiply / divide arithmetic.
module tb_seq_muldiv32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  seq_muldiv32_if bus ();

  seq_muldiv32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the whole operands.
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic edz, output int elat);
    logic [63:0] p;
    if (o == 1'b0) begin
      p   = {32'd0, x} * {32'd0, y};
      eh  = p[63:32];
      el  = p[31:0];
      edz = 1'b0;
      elat = 33;
    end else if (y == 32'd0) begin
      eh  = x;
      el  = 32'hFFFF_FFFF;
      edz = 1'b1;
      elat = 1;
    end else begin
      eh  = x % y;
      el  = x / y;
      edz = 1'b0;
      elat = 33;
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge, idle again.
  task automatic do_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    logic        edz;
    int          elat;
    int          k;
    model(o, x, y, eh, el, edz, elat);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.start = 1'b0;
        check({tag, " busy_after_accept"}, 64'(bus.busy), 64'(elat == 33));
        if (elat == 33) check({tag, " dz_cleared"}, 64'(bus.dz), 64'd0);
      end
    end while (!bus.done && k < 60);
    check({tag, " latency"}, 64'(k), 64'(elat));
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi), 64'(eh));
    check({tag, " lo"}, 64'(bus.lo), 64'(el));
    check({tag, " dz"}, 64'(bus.dz), 64'(edz));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    check({tag, " hold"}, {bus.hi, bus.lo}, {eh, el});
  endtask

  initial begin
    logic [31:0] eh, el;
    logic        edz;
    int          elat;
    int          k;
    int          seen;
    logic        o;
    logic [31:0] x, y;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset dz", 64'(bus.dz), 64'd0);

    // Directed cases
    do_op("mul_3x5", 1'b0, 32'd3, 32'd5);
    do_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div_100_7", 1'b1, 32'd100, 32'd7);
    do_op("div_5_9", 1'b1, 32'd5, 32'd9);
    do_op("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1);
    do_op("div_by_zero", 1'b1, 32'h1234, 32'd0);
    do_op("mul_after_dz", 1'b0, 32'h0001_0000, 32'h0001_0000);

    // Start during RUN is ignored; start in DONE chains with no idle gap.
    model(1'b0, 32'd1000, 32'd2000, eh, el, edz, elat);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd1000; bus.b = 32'd2000;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) bus.start = 1'b0;
      if (k == 10) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'h55; bus.b = 32'd0;
      end
      if (k == 11) bus.start = 1'b0;
    end while (!bus.done && k < 60);
    check("ignore latency", 64'(k), 64'd33);
    check("ignore result", {bus.hi, bus.lo}, {eh, el});
    check("ignore dz", 64'(bus.dz), 64'd0);
    model(1'b1, 32'd1_000_000, 32'd333, eh, el, edz, elat);
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd1_000_000; bus.b = 32'd333;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.start = 1'b0;
        check("b2b done_dropped", 64'(bus.done), 64'd0);
        check("b2b busy", 64'(bus.busy), 64'd1);
      end
    end while (!bus.done && k < 60);
    check("b2b latency", 64'(k), 64'd33);
    check("b2b result", {bus.hi, bus.lo}, {eh, el});
    @(negedge clk);

    // Asynchronous reset mid-RUN aborts the operation.
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst dz", 64'(bus.dz), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("rst no_done_after_abort", 64'(seen), 64'd0);
    do_op("after_rst", 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = x >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), o, x, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
